// File: rtl/disk_drive_emu.sv
// disk_drive_emu -- floppy drive emulator core (nibble-level read/write, stepper).
//
// Read path: nibbles from storage are prefetched into a one-deep register and
// serialised MSB first on rddata, one bit per BIT_CELL fclk cycles, with a
// PULSE_LEN-cycle low pulse for every 1 bit. An empty prefetch register at a
// byte boundary produces one zero cell and an rd_underflow strobe.
// Write path (only with DISK_DRIVE_EMU_WRITE_EN defined): wrdata transitions
// are timed against the bit cell and decoded into nibbles on wr_nib.
// Stepper: four-phase head positioner over half-tracks 0..MAX_HALFTRACK.
//
// Ports:
//   fclk          in   single clock
//   reset         in   synchronous, active-high reset
//   phase[3:0]    in   stepper magnet drive
//   _enbl         in   drive enable, active low
//   _wrreq        in   write request, active low
//   wrdata        in   serial write data, transition = 1 bit
//   wp            in   write-protect switch, 1 = protected
//   rddata        out  serial read data, idle high, low pulse = 1 bit
//   sense         out  write-protect status
//   nib_rd_req    out  request next nibble from storage
//   nib_rd_data   in   nibble from storage
//   nib_rd_valid  in   nib_rd_data valid
//   wr_nib        out  decoded write nibble
//   wr_nib_valid  out  one-cycle strobe qualifying wr_nib
//   rd_underflow  out  one-cycle strobe, no nibble at a byte boundary
//   halftrack     out  current head position
//
// Build option: define DISK_DRIVE_EMU_WRITE_EN to include the write decoder;
// without it the drive always reports write-protected and never emits nibbles.

module disk_drive_emu #(
  parameter int BIT_CELL      = 28,
  parameter int PULSE_LEN     = 7,
  parameter int MAX_HALFTRACK = 69
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic [3:0] phase,
  input  logic       _enbl,
  input  logic       _wrreq,
  input  logic       wrdata,
  input  logic       wp,
  output logic       rddata,
  output logic       sense,
  output logic       nib_rd_req,
  input  logic [7:0] nib_rd_data,
  input  logic       nib_rd_valid,
  output logic [7:0] wr_nib,
  output logic       wr_nib_valid,
  output logic       rd_underflow,
  output logic [6:0] halftrack
);

  localparam int CNT_W = $clog2(BIT_CELL);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CELL - 1);
  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_LEN);
  localparam logic [6:0]       MAXH      = 7'(MAX_HALFTRACK);

  logic w_active;
  logic w_read_mode;

  assign w_active    = ~_enbl;
  assign w_read_mode = w_active & _wrreq;

  // ---------------------------------------------------------------- read path
  logic             r_rd_act;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_sh;
  logic [7:0]       r_pf;
  logic             r_pf_full;
  logic             r_underflow;
  logic             w_wrap;
  logic             w_xfer;

  assign nib_rd_req = w_read_mode & ~r_pf_full & ~reset;
  assign w_xfer     = nib_rd_req & nib_rd_valid;
  assign w_wrap     = r_rd_act & (r_cnt == CNT_LAST);

  // The first read-mode cycle only arms r_rd_act, so every cell (including the
  // first) spans the full counter range 0..BIT_CELL-1.
  always_ff @(posedge fclk) begin
    if (reset) begin
      r_rd_act    <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sh        <= '0;
      r_pf        <= '0;
      r_pf_full   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= 1'b0;
      if (!w_read_mode) begin
        r_rd_act <= 1'b0;
        r_cnt    <= '0;
        r_idx    <= '0;
      end else if (!r_rd_act) begin
        r_rd_act <= 1'b1;
      end else if (w_wrap) begin
        r_cnt <= '0;
        if (r_idx == 3'd7) begin
          if (r_pf_full) begin
            r_sh      <= r_pf;
            r_pf_full <= 1'b0;
            r_idx     <= '0;
          end else begin
            // Underflow: one zero cell, index parked at 7 so the next wrap
            // retries the prefetch register.
            r_sh        <= '0;
            r_underflow <= 1'b1;
          end
        end else begin
          r_sh  <= {r_sh[6:0], 1'b0};
          r_idx <= r_idx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // nib_rd_req implies the register is empty, so this never collides with
      // the boundary load above.
      if (w_xfer) begin
        r_pf      <= nib_rd_data;
        r_pf_full <= 1'b1;
      end
    end
  end

  assign rddata       = ~(r_rd_act & r_sh[7] & (r_cnt < PULSE_END));
  assign rd_underflow = r_underflow;

  // ------------------------------------------------------------------ stepper
  logic [6:0] r_ht;
  logic [1:0] w_p1;
  logic [1:0] w_m1;
  logic       w_up;
  logic       w_dn;

  assign w_p1 = r_ht[1:0] + 2'd1;
  assign w_m1 = r_ht[1:0] - 2'd1;
  assign w_up = phase[w_p1] & ~phase[w_m1];
  assign w_dn = phase[w_m1] & ~phase[w_p1];

  always_ff @(posedge fclk) begin
    if (reset) begin
      r_ht <= '0;
    end else if (w_active) begin
      if (w_up && (r_ht != MAXH)) begin
        r_ht <= r_ht + 7'd1;
      end else if (w_dn && (r_ht != '0)) begin
        r_ht <= r_ht - 7'd1;
      end
    end
  end

  assign halftrack = r_ht;

  // --------------------------------------------------------------- write path
`ifdef DISK_DRIVE_EMU_WRITE_EN
  localparam int WT_W = $clog2(2 * BIT_CELL) + 1;
  localparam logic [WT_W-1:0] WT_HALF    = WT_W'(BIT_CELL / 2);
  localparam logic [WT_W-1:0] WT_ONEHALF = WT_W'(3 * BIT_CELL / 2);

  logic            w_write_mode;
  logic            r_wd_s1;
  logic            r_wd_s2;
  logic [WT_W-1:0] r_wt;
  logic [7:0]      r_wsh;
  logic [7:0]      r_wr_nib;
  logic            r_wr_valid;
  logic            r_sense;
  logic            w_edge;
  logic [7:0]      w_wsh_base;

  assign w_write_mode = w_active & ~_wrreq;
  assign w_edge       = r_wd_s1 ^ r_wd_s2;
  // A completed nibble is handed off and cleared in the same cycle that the
  // next bit (if any) is shifted in.
  assign w_wsh_base   = r_wsh[7] ? '0 : r_wsh;

  always_ff @(posedge fclk) begin
    if (reset) begin
      r_wd_s1    <= 1'b0;
      r_wd_s2    <= 1'b0;
      r_wt       <= '0;
      r_wsh      <= '0;
      r_wr_nib   <= '0;
      r_wr_valid <= 1'b0;
      r_sense    <= 1'b1;
    end else begin
      r_wd_s1    <= wrdata;
      r_wd_s2    <= r_wd_s1;
      r_wr_valid <= 1'b0;
      r_sense    <= w_active ? wp : 1'b1;
      if (r_wsh[7]) begin
        r_wr_nib   <= r_wsh;
        r_wr_valid <= 1'b1;
      end
      if (!w_write_mode) begin
        r_wt  <= '0;
        r_wsh <= '0;
      end else if (w_edge) begin
        r_wt  <= '0;
        r_wsh <= (r_wt >= WT_HALF) ? {w_wsh_base[6:0], 1'b1} : w_wsh_base;
      end else if (r_wt >= WT_ONEHALF) begin
        r_wt  <= WT_HALF;
        r_wsh <= {w_wsh_base[6:0], 1'b0};
      end else begin
        r_wt  <= r_wt + 1'b1;
        r_wsh <= w_wsh_base;
      end
    end
  end

  assign wr_nib       = r_wr_nib;
  assign wr_nib_valid = r_wr_valid;
  assign sense        = r_sense;
`else
  logic w_unused;
  assign w_unused     = ^{wrdata, wp};
  assign wr_nib       = '0;
  assign wr_nib_valid = 1'b0;
  assign sense        = 1'b1;
`endif

endmodule

// File: tb/tb_disk_drive_emu.sv
// Testbench for disk_drive_emu: table of stepper/sense vectors plus directed
// sequences for read serialisation, underflow, mode switch, clamping and (when
// DISK_DRIVE_EMU_WRITE_EN is defined) write decode.

module tb_disk_drive_emu;

  logic       fclk = 1'b0;
  logic       reset;
  logic [3:0] phase;
  logic       _enbl;
  logic       _wrreq;
  logic       wrdata;
  logic       wp;
  logic       rddata;
  logic       sense;
  logic       nib_rd_req;
  logic [7:0] nib_rd_data;
  logic       nib_rd_valid;
  logic [7:0] wr_nib;
  logic       wr_nib_valid;
  logic       rd_underflow;
  logic [6:0] halftrack;

  int nchk = 0;
  int nerr = 0;
  int vcount = 0;
  logic [7:0] vnib = '0;

`ifdef DISK_DRIVE_EMU_WRITE_EN
  localparam int EXP_VCOUNT = 1;
`else
  localparam int EXP_VCOUNT = 0;
`endif

  always #5 fclk = ~fclk;

  disk_drive_emu #(
    .BIT_CELL      (28),
    .PULSE_LEN     (7),
    .MAX_HALFTRACK (69)
  ) dut (
    .fclk         (fclk),
    .reset        (reset),
    .phase        (phase),
    ._enbl        (_enbl),
    ._wrreq       (_wrreq),
    .wrdata       (wrdata),
    .wp           (wp),
    .rddata       (rddata),
    .sense        (sense),
    .nib_rd_req   (nib_rd_req),
    .nib_rd_data  (nib_rd_data),
    .nib_rd_valid (nib_rd_valid),
    .wr_nib       (wr_nib),
    .wr_nib_valid (wr_nib_valid),
    .rd_underflow (rd_underflow),
    .halftrack    (halftrack)
  );

  always @(negedge fclk) begin
    if (wr_nib_valid === 1'b1) begin
      vcount <= vcount + 1;
      vnib   <= wr_nib;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  function automatic logic exp_sense(input logic enbl_n, input logic wp_in);
`ifdef DISK_DRIVE_EMU_WRITE_EN
    return enbl_n ? 1'b1 : wp_in;
`else
    return 1'b1 | enbl_n | wp_in;
`endif
  endfunction

  // Reset is applied with the drive enabled in read mode so that every output
  // default is actually forced by reset, not by idle inputs.
  task automatic do_reset();
    reset        = 1'b1;
    _enbl        = 1'b0;
    _wrreq       = 1'b1;
    phase        = 4'b0000;
    wrdata       = 1'b0;
    wp           = 1'b0;
    nib_rd_data  = 8'h00;
    nib_rd_valid = 1'b0;
    tick();
    tick();
    check("rst_rddata", rddata, 1);
    check("rst_nib_rd_req", nib_rd_req, 0);
    check("rst_wr_nib", wr_nib, 0);
    check("rst_wr_nib_valid", wr_nib_valid, 0);
    check("rst_rd_underflow", rd_underflow, 0);
    check("rst_halftrack", halftrack, 0);
    check("rst_sense", sense, 1);
    _enbl = 1'b1;
    reset = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [3:0] ph;
    logic       enbl_n;
    logic       wrreq_n;
    logic       wp_in;
    logic [6:0] exp_h;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int         exp_h;
    int         c;
    int         k;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       exp_bits [27];
    logic [27:0] obs_rd;
    logic [27:0] obs_uf;
    logic [27:0] exp_rd;
    logic [27:0] exp_uf;

    tbl[0]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 7'd0};
    tbl[1]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 7'd0};
    tbl[2]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 7'd1};
    tbl[3]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 7'd2};
    tbl[4]  = '{4'b1000, 1'b0, 1'b0, 1'b1, 7'd3};
    tbl[5]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 7'd3};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 7'd3};
    tbl[7]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 7'd2};
    tbl[8]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 7'd1};
    tbl[9]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 7'd0};
    tbl[10] = '{4'b1000, 1'b0, 1'b0, 1'b1, 7'd0};
    tbl[11] = '{4'b1010, 1'b0, 1'b0, 1'b0, 7'd0};
    tbl[12] = '{4'b0010, 1'b1, 1'b0, 1'b0, 7'd0};

    do_reset();

    // Stepper and sense vectors
    for (int i = 0; i < 13; i++) begin
      phase  = tbl[i].ph;
      _enbl  = tbl[i].enbl_n;
      _wrreq = tbl[i].wrreq_n;
      wp     = tbl[i].wp_in;
      tick();
      check($sformatf("vec%0d_halftrack", i), halftrack, tbl[i].exp_h);
      check($sformatf("vec%0d_sense", i), sense, exp_sense(tbl[i].enbl_n, tbl[i].wp_in));
    end

    // Step outward every cycle until clamped at the top, then one step back
    _enbl  = 1'b0;
    _wrreq = 1'b0;
    exp_h  = 0;
    for (int i = 0; i < 100; i++) begin
      phase = 4'b0001 << ((exp_h + 1) % 4);
      tick();
      exp_h = (exp_h < 69) ? exp_h + 1 : 69;
    end
    check("clamp_top", halftrack, 69);
    phase = 4'b0001 << ((69 + 3) % 4);
    tick();
    check("step_down_from_top", halftrack, 68);

    // Read serialisation and underflow.
    // Cells 0-7: reset shifter (zeros); 8-15: 0xD5; 16-18: underflow zeros;
    // 19-26: 0x81 fetched late.
    do_reset();
    b1 = 8'hD5;
    b2 = 8'h81;
    for (int i = 0; i < 27; i++) exp_bits[i] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_bits[8 + i]  = b1[7 - i];
      exp_bits[19 + i] = b2[7 - i];
    end
    nib_rd_data  = 8'hD5;
    nib_rd_valid = 1'b1;
    _enbl        = 1'b0;
    _wrreq       = 1'b1;
    #1;
    check("req_on_entry", nib_rd_req, 1);
    tick();
    nib_rd_valid = 1'b0;
    obs_rd = '0;
    obs_uf = '0;
    exp_rd = '0;
    exp_uf = '0;
    for (int n = 0; n < 756; n++) begin
      c = n / 28;
      k = n % 28;
      obs_rd[k] = rddata;
      obs_uf[k] = rd_underflow;
      exp_rd[k] = !(exp_bits[c] && (k < 7));
      exp_uf[k] = (k == 0) && (c >= 16) && (c <= 18);
      if (n == 0)   check("req_low_after_xfer", nib_rd_req, 0);
      if (n == 224) check("req_high_after_load", nib_rd_req, 1);
      if (k == 27) begin
        check($sformatf("rddata_cell%0d", c), obs_rd, exp_rd);
        check($sformatf("underflow_cell%0d", c), obs_uf, exp_uf);
      end
      nib_rd_valid = (n == 519);
      if (n == 519) nib_rd_data = 8'h81;
      tick();
    end
    nib_rd_valid = 1'b0;

    // Mode switch in the middle of a 1-bit pulse
    do_reset();
    nib_rd_data  = 8'hFF;
    nib_rd_valid = 1'b1;
    _enbl        = 1'b0;
    _wrreq       = 1'b1;
    tick();
    nib_rd_valid = 1'b0;
    repeat (226) tick();
    check("pulse_before_switch", rddata, 0);
    check("req_before_switch", nib_rd_req, 1);
    wp     = 1'b0;
    _wrreq = 1'b0;
    tick();
    check("rddata_after_switch", rddata, 1);
    check("req_after_switch", nib_rd_req, 0);
    check("sense_write_mode", sense, exp_sense(1'b0, 1'b0));

`ifdef DISK_DRIVE_EMU_WRITE_EN
    // Write decode of 0x96 at one transition slot per 28 cycles
    do_reset();
    begin
      logic [7:0] pat;
      pat    = 8'h96;
      _enbl  = 1'b0;
      _wrreq = 1'b0;
      wrdata = 1'b0;
      repeat (20) tick();
      for (int i = 0; i < 8; i++) begin
        if (pat[7 - i]) wrdata = ~wrdata;
        repeat (28) tick();
      end
      repeat (100) tick();
      check("wr_nib_value", vnib, 8'h96);
    end
`endif

    check("wr_nib_valid_count", vcount, EXP_VCOUNT);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/disk_drive_emu.md
DISK_DRIVE_EMU -- requirements
Module: disk_drive_emu

Interface
REQ-001 SHALL provide parameter BIT_CELL, default 28: fclk cycles per bit cell (4 us at 7 MHz).
REQ-002 SHALL provide parameter PULSE_LEN, default 7: rddata low-pulse width in fclk cycles.
REQ-003 SHALL provide parameter MAX_HALFTRACK, default 69: highest half-track position.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port fclk  in  1  the single clock.
REQ-006 SHALL provide port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL provide port phase  in  4  stepper magnet drive from the controller.
REQ-008 SHALL provide port _enbl  in  1  drive enable, active low.
REQ-009 SHALL provide port _wrreq  in  1  write request, active low.
REQ-010 SHALL provide port wrdata  in  1  serial write data; each transition is a 1 bit.
REQ-011 SHALL provide port wp  in  1  write-protect switch, 1 = protected.
REQ-012 SHALL provide port rddata  out  1  serial read data, idle high; each low pulse is a 1 bit.
REQ-013 SHALL provide port sense  out  1  write-protect status to the controller.
REQ-014 SHALL provide port nib_rd_req  out  1  request for the next nibble from storage.
REQ-015 SHALL provide port nib_rd_data  in  8  nibble from storage.
REQ-016 SHALL provide port nib_rd_valid  in  1  nib_rd_data is valid.
REQ-017 SHALL provide port wr_nib  out  8  decoded write nibble.
REQ-018 SHALL provide port wr_nib_valid  out  1  one-cycle strobe qualifying wr_nib.
REQ-019 SHALL provide port rd_underflow  out  1  one-cycle strobe; no nibble was available at a byte boundary.
REQ-020 SHALL provide port halftrack  out  7  current head position.

Function
REQ-021 SHALL define active = (_enbl==0). SHALL define read mode = active & _wrreq==1. SHALL define write mode = active & _wrreq==0.
REQ-022 SHALL hold a one-nibble prefetch register. SHALL drive nib_rd_req high while in read mode and the prefetch register is empty.
REQ-023 SHALL transfer a nibble into the prefetch register on a cycle where nib_rd_req & nib_rd_valid are both high. nib_rd_req SHALL be low the following cycle.
REQ-024 SHALL run a read cell counter 0..BIT_CELL-1 in read mode, wrapping to 0.
REQ-025 SHALL hold a 3-bit bit index. The index SHALL advance on each counter wrap.
REQ-026 SHALL shift the output shifter out MSB first, one bit per cell.
REQ-027 For a 1 bit, SHALL drive rddata low for cell-counter values 0..PULSE_LEN-1. Otherwise rddata SHALL be high.
REQ-028 At a byte boundary (wrap with index 7), SHALL move the prefetch register into the shifter if it is full and mark the prefetch register empty.
REQ-029 At a byte boundary with the prefetch register empty, SHALL load the shifter with zeros for exactly one bit cell, hold the index at 7, and pulse rd_underflow.
REQ-030 SHALL synchronise wrdata through two fclk flops. A transition between the synchronised stages SHALL be an edge.
REQ-031 In write mode, an edge with write timer >= BIT_CELL/2 SHALL shift a 1 into the LSB of the write shifter. Any edge SHALL reset the write timer to 0.
REQ-032 With no edge and write timer >= 3*BIT_CELL/2, SHALL shift a 0 into the LSB and set the write timer to BIT_CELL/2. Otherwise the write timer SHALL increment.
REQ-033 When write-shifter bit 7 is 1, SHALL copy the write shifter to wr_nib, pulse wr_nib_valid for one cycle the next cycle, and clear the write shifter.
REQ-034 Let h = halftrack. If phase[(h+1)%4] is on and phase[(h-1)%4] is off, SHALL set h = min(h+1, MAX_HALFTRACK).
REQ-035 If phase[(h-1)%4] is on and phase[(h+1)%4] is off, SHALL set h = max(h-1, 0). In all other cases h SHALL be held.
REQ-036 SHALL perform at most one step per cycle, and only while active.
REQ-037 SHALL drive sense = wp while active and 1 when not active.
REQ-038 On a leaving-read-mode event (inactive, or _wrreq falling), SHALL reset the read counter and index to 0, force rddata high and drop nib_rd_req; the prefetch register SHALL be retained.
REQ-039 On entering write mode, SHALL reset the write timer and write shifter to 0. A partially decoded nibble SHALL be discarded on leaving write mode.

Reset
REQ-040 On reset, SHALL set rddata=1, nib_rd_req=0, wr_nib=0, wr_nib_valid=0, rd_underflow=0, halftrack=0, and sense=1.
REQ-041 On reset, SHALL clear all counters, shifters and synchroniser flops, and empty the prefetch register.
REQ-042 Reset mid-byte SHALL take precedence over every other update in the same cycle.

Configuration
REQ-043 With macro DISK_DRIVE_EMU_WRITE_EN defined, SHALL include the write-decode path per REQ-030..REQ-033.
REQ-044 With DISK_DRIVE_EMU_WRITE_EN undefined, SHALL tie wr_nib_valid=0 and wr_nib=0, drive sense=1 (always write-protected), and omit the write path logic.

Verification
REQ-045 Verify read serialisation: read mode, storage returns 0xD5 immediately -> rddata pulses low 7 cycles at cell starts of bits 7,6,4,2,0 (pattern 11010101), one cell per 28 cycles.
REQ-046 Verify read underflow: nib_rd_valid held low after first nibble -> one zero cell at the boundary, rd_underflow pulses once per 28 cycles until valid returns.
REQ-047 Verify write decode: write mode, wrdata toggles at 28-cycle spacing for pattern 10010110 -> wr_nib=0x96 with a single wr_nib_valid strobe.
REQ-048 Verify stepping and clamping: halftrack=0, energise phase1 then phase2 then phase3 one at a time -> halftrack 1,2,3. At halftrack 0 energise phase3 only -> halftrack stays 0.
REQ-049 Verify mode switch: _wrreq falls mid-read-byte -> rddata high next cycle, nib_rd_req low. With DISK_DRIVE_EMU_WRITE_EN undefined, sense=1 and wr_nib_valid never asserts.
